fetch_unit: RTL and testbench

Instruction fetch stage of the single-issue CPU. Holds the program counter and drives the word address of the asynchronous 256x32 instruction ROM. Registers the returned word with its PC into a valid/ready output register for decode. Accepts branch/jump redirects from execute, supports halt requests and counts delivered instructions.

---
 rtl/fetch_pkg.sv | 6 +
 rtl/fetch_unit.sv | 100 ++++++++++
 tb/tb_fetch_unit.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: constants and FSM state type shared by the fetch stage and its bench.
package fetch_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} fetch_state_t;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: PC, ROM address, valid/ready instruction register, redirect, halt FSM and fetch counter.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int ROM_AW = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       instr,
    output logic [31:0]       instr_pc,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              redirect_misaligned,
    input  logic              halt_req,
    output logic              halted,
    output logic [31:0]       fetch_count
);
    logic [31:0]  pc_q, pc_d, instr_q, instr_d, instr_pc_q, instr_pc_d, count_q, count_d;
    logic         valid_q, valid_d, mis_q, mis_d, hs, load, stall;
    fetch_state_t state_q, state_d;

    assign hs    = valid_q && out_ready;
    assign stall = valid_q && !out_ready;
    assign load  = state_q == RUN && !halt_req && !stall;

    always_comb begin
        pc_d       = pc_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        mis_d      = 1'b0;
        count_d    = count_q + {31'b0, hs};
        state_d    = state_q;
        // Redirect overrides load, hold and FSM, squashing any held instruction.
        if (redirect_valid) begin
            pc_d    = {redirect_pc[31:2], 2'b00};
            valid_d = 1'b0;
            mis_d   = |redirect_pc[1:0];
            state_d = halt_req ? HALTED : RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (halt_req) begin
                        state_d = stall ? DRAIN : HALTED;
                        valid_d = stall;
                    end else if (load) begin
                        instr_d    = rom_data;
                        instr_pc_d = pc_q;
                        valid_d    = 1'b1;
                        pc_d       = pc_q + 32'd4;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        valid_d = 1'b0;
                        state_d = HALTED;
                    end
                end
                HALTED: begin
                    valid_d = 1'b0;
                    state_d = halt_req ? HALTED : RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
            instr_pc_q <= 32'h0;
            mis_q      <= 1'b0;
            count_q    <= 32'h0;
            state_q    <= RUN;
        end else begin
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            mis_q      <= mis_d;
            count_q    <= count_d;
            state_q    <= state_d;
        end
    end

    assign rom_addr            = pc_q[ROM_AW+1:2];
    assign out_valid           = valid_q;
    assign instr               = instr_q;
    assign instr_pc            = instr_pc_q;
    assign redirect_misaligned = mis_q;
    assign halted              = state_q == HALTED;
    assign fetch_count         = count_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plan plus random traffic checked against a rule-level fetch model.
module tb_fetch_unit;
    logic        clk = 1'b0, rst = 1'b1, out_ready = 1'b0, redirect_valid = 1'b0, halt_req = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data, instr, instr_pc, fetch_count;
    logic        out_valid, redirect_misaligned, halted;
    logic [31:0] rom [256];
    int          total = 0, bad = 0;

    logic [31:0] m_pc = 0, m_instr = 32'h13, m_ipc = 0, m_cnt = 0;
    logic        m_valid = 0, m_mis = 0, m_halted = 0, m_drain = 0;

    fetch_unit dut (
        .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data),
        .out_valid(out_valid), .out_ready(out_ready), .instr(instr), .instr_pc(instr_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_misaligned(redirect_misaligned), .halt_req(halt_req),
        .halted(halted), .fetch_count(fetch_count)
    );

    assign rom_data = rom[rom_addr];
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Next state of the model from the behavioural rules, using the inputs about to be sampled.
    task automatic model_next();
        logic hs;
        if (rst) begin
            m_pc = 32'h0; m_valid = 0; m_instr = 32'h13; m_ipc = 0; m_mis = 0; m_cnt = 0;
            m_halted = 0; m_drain = 0;
            return;
        end
        hs = m_valid && out_ready;
        if (hs) m_cnt = m_cnt + 1;
        m_mis = 0;
        if (redirect_valid) begin
            m_pc = redirect_pc & 32'hFFFF_FFFC;
            m_valid = 0;
            m_mis = redirect_pc[1:0] != 2'b00;
            m_halted = halt_req;
            m_drain = 0;
        end else if (m_halted) begin
            m_valid = 0;
            if (!halt_req) m_halted = 0;
        end else if (m_drain) begin
            if (out_ready) begin m_valid = 0; m_drain = 0; m_halted = 1; end
        end else if (halt_req) begin
            if (m_valid && !out_ready) m_drain = 1;
            else begin m_valid = 0; m_halted = 1; end
        end else if (!m_valid || out_ready) begin
            m_instr = rom[m_pc[9:2]];
            m_ipc = m_pc;
            m_valid = 1;
            m_pc = m_pc + 4;
        end
    endtask

    task automatic step(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc, input logic h);
        rst = r; out_ready = rdy; redirect_valid = rv; redirect_pc = rpc; halt_req = h;
        model_next();
        @(posedge clk);
        #1;
        check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        check("instr", instr, m_instr);
        check("instr_pc", instr_pc, m_ipc);
        check("rom_addr", {24'b0, rom_addr}, {24'b0, m_pc[9:2]});
        check("misaligned", {31'b0, redirect_misaligned}, {31'b0, m_mis});
        check("halted", {31'b0, halted}, {31'b0, m_halted});
        check("fetch_count", fetch_count, m_cnt);
    endtask

    initial begin
        logic h;
        for (int i = 0; i < 256; i++) rom[i] = $urandom;
        rom[0] = 32'h07d0_0613; rom[1] = 32'h02c0_2023; rom[2] = 32'h02c0_2023;
        #2;
        step(1, 0, 0, 0, 0);
        check("reset_instr", instr, 32'h0000_0013);
        check("reset_valid", {31'b0, out_valid}, 32'h0);
        step(0, 1, 0, 0, 0);
        check("first_pc", instr_pc, 32'h0);
        check("first_word", instr, 32'h07d0_0613);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        check("third_pc", instr_pc, 32'h8);
        check("third_word", instr, 32'h02c0_2023);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        check("stall_pc", instr_pc, 32'h8);
        check("stall_cnt", fetch_count, 32'd2);
        step(0, 1, 0, 0, 0);
        check("resume_pc", instr_pc, 32'hC);
        step(0, 0, 1, 32'h40, 0);
        check("redir_squash", {31'b0, out_valid}, 32'h0);
        check("redir_rom_addr", {24'b0, rom_addr}, 32'h10);
        step(0, 1, 0, 0, 0);
        check("redir_target", instr_pc, 32'h40);
        step(0, 1, 1, 32'h42, 0);
        check("mis_pulse", {31'b0, redirect_misaligned}, 32'h1);
        step(0, 1, 0, 0, 0);
        check("mis_clear", {31'b0, redirect_misaligned}, 32'h0);
        check("mis_target", instr_pc, 32'h40);
        step(0, 0, 0, 0, 1);
        check("drain_hold", {31'b0, out_valid}, 32'h1);
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        check("drain_halted", {31'b0, halted}, 32'h1);
        check("drain_empty", {31'b0, out_valid}, 32'h0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        check("unhalt_pc", instr_pc, 32'h44);
        step(0, 1, 1, 32'h3F8, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        check("wrap_pc", instr_pc, 32'h400);
        check("wrap_word", instr, rom[0]);
        step(1, 1, 0, 0, 0);
        check("rst_count", fetch_count, 32'h0);
        check("rst_instr", instr, 32'h0000_0013);
        step(0, 1, 0, 0, 0);
        check("restart_pc", instr_pc, 32'h0);
        h = 0;
        for (int i = 0; i < 600; i++) begin
            logic [31:0] tgt;
            if ($urandom_range(9) == 0) h = ~h;
            tgt = $urandom_range(3) == 0 ? 32'hFFFF_FFF0 | $urandom_range(15) : $urandom;
            step($urandom_range(63) == 0, $urandom_range(2) != 0, $urandom_range(7) == 0, tgt, h);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
